// File: rtl/lzw_stream_enc.sv
// Streaming LZW encoder: 8-bit symbols in, fixed-width CODE_W codes out, with a sequentially searched dictionary.
// Optional feature macro LZW_DICT_RESET_EN: when the dictionary fills, emit CLEAR (2^CODE_W-1) and restart it.
module lzw_stream_enc #(
    parameter int CODE_W     = 12,
    parameter int DICT_DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sym_valid_i,
    output logic              sym_ready_o,
    input  logic [7:0]        sym_i,
    input  logic              sym_last_i,
    output logic              code_valid_o,
    input  logic              code_ready_i,
    output logic [CODE_W-1:0] code_o,
    output logic              code_last_o,
    output logic              dict_full_o,
    output logic              busy_o
);
    localparam int IDX_W = (DICT_DEPTH > 1) ? $clog2(DICT_DEPTH) : 1;
    localparam int CNT_W = $clog2(DICT_DEPTH + 1);
    localparam logic [CODE_W-1:0] LIT_BASE = CODE_W'(32'd256);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DICT_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_SEARCH    = 3'd1,
        ST_EMIT      = 3'd2,
        ST_EMIT_LAST = 3'd3
`ifdef LZW_DICT_RESET_EN
        , ST_EMIT_CLR = 3'd4
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  cur_q, cur_d;
    logic               cur_v_q, cur_v_d;
    logic [7:0]         pend_q, pend_d;
    logic               pend_last_q, pend_last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   dict_count_q, dict_count_d;
    logic               sym_ready_q, sym_ready_d;
    logic               code_valid_q, code_valid_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               code_last_q, code_last_d;
    logic               dict_full_q, dict_full_d;
    logic               busy_q, busy_d;

    logic [CODE_W-1:0]  dict_prefix_q [DICT_DEPTH];
    logic [7:0]         dict_sym_q    [DICT_DEPTH];
    logic               dict_we_s;

    logic               sym_fire_s;
    logic               code_fire_s;
    logic               hit_s;
    logic               last_idx_s;
    logic               full_s;

    assign sym_fire_s  = sym_valid_i & sym_ready_q;
    assign code_fire_s = code_valid_q & code_ready_i;
    assign hit_s       = (dict_prefix_q[idx_q] == cur_q) && (dict_sym_q[idx_q] == pend_q);
    assign last_idx_s  = ((CNT_W'(idx_q) + CNT_W'(1'b1)) == dict_count_q);
    assign full_s      = (dict_count_q == CNT_FULL);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        cur_v_d      = cur_v_q;
        pend_d       = pend_q;
        pend_last_d  = pend_last_q;
        idx_d        = idx_q;
        dict_count_d = dict_count_q;
        dict_we_s    = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (sym_fire_s) begin
                    if (!cur_v_q) begin
                        // First symbol of a message only seeds the current string.
                        cur_d   = CODE_W'(sym_i);
                        cur_v_d = 1'b1;
                        if (sym_last_i) state_d = ST_EMIT_LAST;
                        else            state_d = ST_WAIT;
                    end else begin
                        pend_d      = sym_i;
                        pend_last_d = sym_last_i;
                        idx_d       = {IDX_W{1'b0}};
                        state_d     = ST_SEARCH;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SEARCH: begin
                if (dict_count_q == CNT_ZERO) begin
                    state_d = ST_EMIT;
                end else if (hit_s) begin
                    cur_d = LIT_BASE + CODE_W'(idx_q);
                    if (pend_last_q) state_d = ST_EMIT_LAST;
                    else             state_d = ST_WAIT;
                end else if (last_idx_s) begin
                    state_d = ST_EMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1'b1);
                end
            end
            ST_EMIT: begin
                if (code_fire_s) begin
                    if (full_s) begin
                        dict_we_s = 1'b0;
                    end else begin
                        dict_we_s    = 1'b1;
                        dict_count_d = dict_count_q + CNT_W'(1'b1);
                    end
                    cur_d = CODE_W'(pend_q);
`ifdef LZW_DICT_RESET_EN
                    if (full_s)           state_d = ST_EMIT_CLR;
                    else if (pend_last_q) state_d = ST_EMIT_LAST;
                    else                  state_d = ST_WAIT;
`else
                    if (pend_last_q) state_d = ST_EMIT_LAST;
                    else             state_d = ST_WAIT;
`endif
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT_LAST: begin
                if (code_fire_s) begin
                    cur_v_d      = 1'b0;
                    dict_count_d = CNT_ZERO;
                    state_d      = ST_WAIT;
                end else begin
                    state_d = ST_EMIT_LAST;
                end
            end
`ifdef LZW_DICT_RESET_EN
            ST_EMIT_CLR: begin
                if (code_fire_s) begin
                    dict_count_d = CNT_ZERO;
                    if (pend_last_q) state_d = ST_EMIT_LAST;
                    else             state_d = ST_WAIT;
                end else begin
                    state_d = ST_EMIT_CLR;
                end
            end
`endif
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // Outputs are registered from the next state so they change only on transitions.
        sym_ready_d  = (state_d == ST_WAIT);
        code_valid_d = (state_d != ST_WAIT) && (state_d != ST_SEARCH);
        code_last_d  = (state_d == ST_EMIT_LAST);
`ifdef LZW_DICT_RESET_EN
        if (state_d == ST_EMIT_CLR) code_d = {CODE_W{1'b1}};
        else if (code_valid_d)      code_d = cur_d;
        else                        code_d = code_q;
`else
        if (code_valid_d) code_d = cur_d;
        else              code_d = code_q;
`endif
        dict_full_d = (dict_count_d == CNT_FULL);
        busy_d      = cur_v_d | (state_d != ST_WAIT);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_WAIT;
            cur_q        <= {CODE_W{1'b0}};
            cur_v_q      <= 1'b0;
            pend_q       <= 8'd0;
            pend_last_q  <= 1'b0;
            idx_q        <= {IDX_W{1'b0}};
            dict_count_q <= CNT_ZERO;
            sym_ready_q  <= 1'b1;
            code_valid_q <= 1'b0;
            code_q       <= {CODE_W{1'b0}};
            code_last_q  <= 1'b0;
            dict_full_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            cur_v_q      <= cur_v_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            idx_q        <= idx_d;
            dict_count_q <= dict_count_d;
            sym_ready_q  <= sym_ready_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
            code_last_q  <= code_last_d;
            dict_full_q  <= dict_full_d;
            busy_q       <= busy_d;
        end
    end

    // Dictionary storage; entries at or above dict_count are never compared, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (dict_we_s) begin
            dict_prefix_q[dict_count_q[IDX_W-1:0]] <= cur_q;
            dict_sym_q[dict_count_q[IDX_W-1:0]]    <= pend_q;
        end
    end

    assign sym_ready_o  = sym_ready_q;
    assign code_valid_o = code_valid_q;
    assign code_o       = code_q;
    assign code_last_o  = code_last_q;
    assign dict_full_o  = dict_full_q;
    assign busy_o       = busy_q;

endmodule

// File: doc/lzw_stream_enc.md
# lzw_stream_enc

Parametrised streaming LZW encoder, the successor to the fixed 14-byte, free-running compressor. It accepts 8-bit symbols of arbitrary-length messages over a valid/ready input and emits variable-value, fixed-width LZW codes over a valid/ready output. The learned dictionary has configurable depth and is searched sequentially, one entry per cycle. It sits between the byte source and the code packer in the compression datapath.

## Interface
- `CODE_W`, 12: output code width.
  - Literals are codes 0..255.
  - Learned entries are codes 256..256+DICT_DEPTH-1.
- `DICT_DEPTH`, 256: number of learned entries. Legal only if 256+DICT_DEPTH <= 2^CODE_W-1.
- `clk_i` input 1: clock.
- `reset_i` input 1: reset; asynchronous, active-high.
- `sym_valid_i` input 1: input symbol valid.
- `sym_ready_o` output 1: encoder accepts a symbol.
- `sym_i` input 8: input symbol.
- `sym_last_i` input 1: symbol is the last of its message.
- `code_valid_o` output 1: output code valid.
- `code_ready_i` input 1: downstream accepts the code.
- `code_o` output CODE_W: output code.
- `code_last_o` output 1: final code of the message.
- `dict_full_o` output 1: dictionary count equals DICT_DEPTH.
- `busy_o` output 1: a message is in progress (current string held or FSM not in WAIT).

## Operation
- Registered state:
  - `cur` (CODE_W bits) and `cur_v`.
  - `pend` (8 bits) and `pend_last`.
  - `idx` and `dict_count` (0..DICT_DEPTH).
  - Entry array `{prefix[CODE_W], sym[8]}` x DICT_DEPTH.
- FSM states: WAIT, SEARCH, EMIT, EMIT_LAST, and EMIT_CLR (macro only).
- **WAIT**
  - `sym_ready_o`=1; a symbol is accepted on `sym_valid_i` & `sym_ready_o`.
  - If `cur_v`=0: `cur`←sym, `cur_v`←1.
    - If `sym_last_i`=1, go to EMIT_LAST.
    - Otherwise stay in WAIT.
  - If `cur_v`=1: `pend`←sym, `pend_last`←`sym_last_i`, `idx`←0, go to SEARCH.
- **SEARCH**
  - Each cycle, compare entry `idx` against `{cur, pend}`.
  - Hit: `cur`←256+idx. If `pend_last`, go to EMIT_LAST; otherwise go to WAIT.
  - No hit and `idx`<`dict_count`-1: `idx`++.
  - `idx`=`dict_count`-1 with no hit, or `dict_count`=0: go to EMIT with `code_o`=`cur`.
- **EMIT**
  - `code_valid_o`=1, `code_last_o`=0.
  - On handshake:
    - If `dict_count`<DICT_DEPTH, write entry[`dict_count`]←`{cur,pend}` and `dict_count`++.
    - Set `cur`←pend.
    - Next state: EMIT_CLR if the dictionary was full and the macro is set; else EMIT_LAST if `pend_last`; else WAIT.
- **EMIT_LAST**
  - `code_o`=`cur`, `code_last_o`=1.
  - On handshake: `cur_v`←0, `dict_count`←0 (dictionary cleared per message), go to WAIT.
- **Output stability:** `code_o` and `code_last_o` hold stable while `code_valid_o`=1 and `code_ready_i`=0. `code_valid_o` never drops without a handshake.
- **Full dictionary (macro off):** entries are frozen and no new entries are added. `dict_full_o`=1 until the message ends. Encoding continues using the existing entries.
- **Reset mid-operation:** the FSM returns to WAIT, `cur_v`=0, `dict_count`=0, and any in-flight code is dropped.
- **Value range:** all code arithmetic is unsigned CODE_W bits, and `cur` never exceeds 256+DICT_DEPTH-1.

## Timing
- Reset values:
  - `sym_ready_o`=1 (WAIT).
  - `code_valid_o`=0, `code_o`=0, `code_last_o`=0.
  - `dict_full_o`=0, `busy_o`=0.
- First symbol of a message: absorbed in WAIT, so a back-to-back next symbol is accepted the following cycle.
- Symbol accepted at cycle T:
  - A hit on entry k resolves in cycle T+1+k, and `sym_ready_o` rises at T+2+k.
  - A miss asserts `code_valid_o` at T+1+max(`dict_count`,1).
- After a code handshake at cycle H, `sym_ready_o` is 1 at H+1 when the next state is WAIT.
- `sym_ready_o`=0 in all states other than WAIT.

## Configuration
- `LZW_DICT_RESET_EN` defined:
  - When EMIT completes with `dict_count`=DICT_DEPTH, the FSM enters EMIT_CLR.
  - EMIT_CLR emits CLEAR code 2^CODE_W-1 with `code_last_o`=0.
  - On that handshake: `dict_count`←0, `dict_full_o`←0, then continue as EMIT would (EMIT_LAST if `pend_last`, else WAIT).
- Undefined: no CLEAR code exists and the dictionary freezes when full.

## Test plan
- **"banana_bandana"**, 14 symbols, `sym_last_i` on the final 'a', `code_ready_i`=1 → codes 98, 97, 110, 257, 97, 95, 256, 110, 100, 259. Only 259 has `code_last_o`=1; `dict_count` is 9 before the message-end clear.
- **Single symbol** 0x41 with `sym_last_i` → one code 65, `code_last_o`=1, `code_valid_o` at T+1. Then `busy_o`=0 and `dict_full_o`=0.
- **Message-boundary clear:** message "aa", then message "aaa" → first message gives 97, 97(last); second gives 97, 256(last), proving the dictionary was cleared between messages.
- **Backpressure:** hold `code_ready_i`=0 for 5 cycles during the first banana code → `code_o`=98 and `code_valid_o`=1 stay stable, `sym_ready_o`=0, and no symbol is lost.
- **Full dictionary, CODE_W=9, DICT_DEPTH=2, "abcd":**
  - Macro off → 97, 98, 99, 100(last); `dict_full_o`=1 after the second code.
  - Macro on → 97, 98, 99, 511, 100(last); `dict_full_o`=0 after 511.
- **Async reset** asserted during SEARCH → all outputs at reset values immediately. A fresh "ab" message afterwards gives 97, 98(last).
